mdc_commutator: RTL and testbench

Radix-2 multi-path delay commutator that sits directly downstream of the butterfly unit (`BU2_FFT`) in the pipelined NTT datapath. It consumes the butterfly's (`fft_a`, `fft_b`, `BU_valid`) stream and re-pairs samples that are `DELAY` apart, so the next butterfly stage receives correctly matched `in1`/`in2` operands. A small FSM self-drains the last half-block after a block-final marker. The modulus is carried alongside for the next stage.

---
 rtl/mdc_commutator.sv | 151 +++++++++++++++
 tb/tb_mdc_commutator.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdc_commutator.sv
// Radix-2 multi-path delay commutator: re-pairs butterfly outputs DELAY samples apart.
// Optional protocol checking on err is built only when MDC_ERR_CHECK_EN is defined.
module mdc_commutator #(
    parameter int DELAY   = 4,
    parameter int D_width = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [D_width-1:0] in_a,
    input  logic [D_width-1:0] in_b,
    input  logic [D_width-1:0] modulus_in,
    output logic               out_valid,
    output logic [D_width-1:0] out_up,
    output logic [D_width-1:0] out_down,
    output logic               out_last,
    output logic [D_width-1:0] modulus_out,
    output logic               busy,
    output logic               err
);

    localparam int              PW     = $clog2(2 * DELAY);
    localparam logic [PW-1:0]   P_D    = PW'(DELAY);
    localparam logic [PW-1:0]   P_DM1  = PW'(DELAY - 1);
    localparam logic [PW-1:0]   P_LAST = PW'(2 * DELAY - 1);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

    state_t              r_state, w_state_nxt;
    logic [PW-1:0]       r_p, w_p_nxt, w_pm;
    logic                w_accept, w_hi, w_emit_a, w_emit_b, w_last_nxt;

    logic [D_width-1:0]  r_a_line [2*DELAY];
    logic [D_width-1:0]  r_b_line [2*DELAY];
    logic [D_width-1:0]  r_mod_cur, r_mod_b;

    logic                r_vld_p1, r_last_p1;
    logic [D_width-1:0]  r_up_p1, r_down_p1, r_mod_p1;

    assign in_ready = (r_state != DRAIN);
    assign busy     = (r_state != IDLE);
    assign w_accept = in_valid && in_ready;
    assign w_hi     = (r_p >= P_D);
    // p - DELAY modulo the block length: partner slot for both a- and b-pairs
    assign w_pm     = r_p - P_D;

    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_emit_a    = 1'b0;
        w_emit_b    = 1'b0;
        w_last_nxt  = 1'b0;
        case (r_state)
            IDLE, FILL: begin
                if (w_accept) begin
                    w_p_nxt     = r_p + PW'(1);
                    w_state_nxt = (r_p == P_DM1) ? STREAM : FILL;
                end
            end
            STREAM: begin
                if (w_accept) begin
                    w_p_nxt  = r_p + PW'(1);
                    w_emit_a = w_hi;
                    w_emit_b = !w_hi;
                    if (in_last && r_p == P_LAST)
                        w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_emit_b = 1'b1;
                w_p_nxt  = r_p + PW'(1);
                if (r_p == P_DM1) begin
                    w_last_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                    w_p_nxt     = '0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_p     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
        end
    end

    // Stage p0: delay lines and per-block modulus capture
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a_line[r_p] <= in_a;
            r_b_line[r_p] <= in_b;
            if (r_p == '0)
                r_mod_cur <= modulus_in;
        end
        if (w_emit_a && r_p == P_D)
            r_mod_b <= r_mod_cur;
    end

    // Stage p1: registered output pair
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
            r_up_p1   <= '0;
            r_down_p1 <= '0;
            r_mod_p1  <= '0;
        end else begin
            r_vld_p1  <= w_emit_a || w_emit_b;
            r_last_p1 <= w_last_nxt;
            if (w_emit_a) begin
                r_up_p1   <= r_a_line[w_pm];
                r_down_p1 <= in_a;
                r_mod_p1  <= r_mod_cur;
            end else if (w_emit_b) begin
                r_up_p1   <= r_b_line[r_p];
                r_down_p1 <= r_b_line[w_pm];
                r_mod_p1  <= r_mod_b;
            end
        end
    end

    assign out_valid   = r_vld_p1;
    assign out_last    = r_last_p1;
    assign out_up      = r_up_p1;
    assign out_down    = r_down_p1;
    assign modulus_out = r_mod_p1;

`ifdef MDC_ERR_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (!rst)
            r_err <= 1'b0;
        else
            r_err <= (w_accept && in_last && r_p != P_LAST) ||
                     (in_valid && r_state == DRAIN);
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mdc_commutator.sv
// Self-checking bench for mdc_commutator (DELAY=2) against a block-level pairing model.
// Checks err pulses when built with MDC_ERR_CHECK_EN, and err stuck at 0 otherwise.
module tb_mdc_commutator;

    localparam int DL = 2;
    localparam int W  = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0, modulus_in = '0;
    logic         in_ready, out_valid, out_last, busy, err;
    logic [W-1:0] out_up, out_down, modulus_out;

    mdc_commutator #(.DELAY(DL), .D_width(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_a(in_a), .in_b(in_b), .modulus_in(modulus_in), .out_valid(out_valid),
        .out_up(out_up), .out_down(out_down), .out_last(out_last), .modulus_out(modulus_out),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: k-th accept of the current block, stored blocks, pending drain steps
    int           m_k = 0, m_drain = 0;
    logic         m_have_prev = 1'b0, m_ready = 1'b1;
    logic [W-1:0] m_a [2*DL], m_b [2*DL], m_pb [2*DL];
    logic [W-1:0] m_mod = '0, m_pmod = '0;

    logic         exp_vld = 0, exp_last = 0, exp_ready = 1, exp_busy = 0, exp_err = 0;
    logic [W-1:0] exp_up = '0, exp_down = '0, exp_mod = '0;

    logic [W-1:0] cap_up [32], cap_dn [32], cap_md [32];
    logic         cap_last [32];
    int           cap_cyc [32];
    int           ncap, rdy_low, n_err;

    task automatic model_reset();
        m_k = 0; m_drain = 0; m_have_prev = 1'b0; m_ready = 1'b1;
        exp_vld = 0; exp_last = 0; exp_ready = 1; exp_busy = 0; exp_err = 0;
    endtask

    task automatic tick(input logic v, input logic l, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] md);
        logic acc, e;
        in_valid = v; in_last = l; in_a = a; in_b = b; modulus_in = md;
        @(posedge clk);
        acc = v && m_ready;
        e = 1'b0; exp_vld = 1'b0; exp_last = 1'b0;
        if (m_drain > 0) begin
            exp_vld = 1'b1;
            exp_up = m_pb[DL - m_drain]; exp_down = m_pb[2*DL - m_drain]; exp_mod = m_pmod;
            m_drain--;
            if (m_drain == 0) begin exp_last = 1'b1; m_have_prev = 1'b0; end
            if (v) e = 1'b1;
        end else if (acc) begin
            if (l && m_k != 2*DL-1) e = 1'b1;
            if (m_k == 0) m_mod = md;
            m_a[m_k] = a; m_b[m_k] = b;
            if (m_k >= DL) begin
                exp_vld = 1'b1; exp_up = m_a[m_k-DL]; exp_down = a; exp_mod = m_mod;
            end else if (m_have_prev) begin
                exp_vld = 1'b1; exp_up = m_pb[m_k]; exp_down = m_pb[m_k+DL]; exp_mod = m_pmod;
            end
            if (m_k == 2*DL-1) begin
                m_pb = m_b; m_pmod = m_mod; m_have_prev = 1'b1;
                if (l) m_drain = DL;
            end
            m_k = (m_k + 1) % (2*DL);
        end
        m_ready   = (m_drain == 0);
        exp_ready = m_ready;
        exp_busy  = (m_k != 0) || m_have_prev || (m_drain != 0);
`ifdef MDC_ERR_CHECK_EN
        exp_err = e;
`else
        exp_err = 1'b0;
`endif
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'($urandom_range(0, 1)); in_last = 1'($urandom_range(0, 1));
            in_a = W'($urandom()); in_b = W'($urandom());
            @(posedge clk); #1; cyc++;
            n_tests++;
            if (out_valid !== 0 || out_last !== 0 || err !== 0 || out_up !== 0 || out_down !== 0 ||
                modulus_out !== 0 || in_ready !== 1 || busy !== 0) begin
                n_fail++;
                $display("FAIL reset cyc=%0d got v%b l%b e%b up%0d dn%0d m%0d r%b b%b, want all 0 with ready=1",
                         cyc, out_valid, out_last, err, out_up, out_down, modulus_out, in_ready, busy);
            end
        end
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_single_block();
        logic [W-1:0] eu [4], ed [4];
        eu = '{1, 2, 11, 12}; ed = '{3, 4, 13, 14};
        ncap = 0; rdy_low = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 4) tick(1'b1, 1'(i == 3), W'(i+1), W'(i+11), W'(193));
            else       tick(1'b0, 1'b0, '0, '0, '0);
            n_tests++;
            if (out_valid !== exp_vld || in_ready !== exp_ready || busy !== exp_busy || err !== exp_err ||
                out_last !== exp_last || (exp_vld && (out_up !== exp_up || out_down !== exp_down || modulus_out !== exp_mod))) begin
                n_fail++;
                $display("FAIL single cyc=%0d got v%b r%b b%b e%b l%b %0d/%0d m%0d, want v%b r%b b%b e%b l%b %0d/%0d m%0d",
                         cyc, out_valid, in_ready, busy, err, out_last, out_up, out_down, modulus_out,
                         exp_vld, exp_ready, exp_busy, exp_err, exp_last, exp_up, exp_down, exp_mod);
            end
            if (out_valid && ncap < 32) begin
                cap_up[ncap] = out_up; cap_dn[ncap] = out_down; cap_md[ncap] = modulus_out;
                cap_last[ncap] = out_last; cap_cyc[ncap] = cyc; ncap++;
            end
            if (!in_ready) rdy_low++;
        end
        n_tests++;
        if (ncap != 4) begin n_fail++; $display("FAIL single_count got %0d pairs, want 4", ncap); end
        for (int i = 0; i < 4 && i < ncap; i++) begin
            n_tests++;
            if (cap_up[i] !== eu[i] || cap_dn[i] !== ed[i] || cap_md[i] !== W'(193) || cap_last[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL single_pair%0d got (%0d,%0d) m%0d l%b, want (%0d,%0d) m193 l%b",
                         i, cap_up[i], cap_dn[i], cap_md[i], cap_last[i], eu[i], ed[i], (i == 3));
            end
            if (i > 0) begin
                n_tests++;
                if (cap_cyc[i] != cap_cyc[i-1] + 1) begin
                    n_fail++;
                    $display("FAIL single_gap%0d got cycle %0d, want %0d", i, cap_cyc[i], cap_cyc[i-1] + 1);
                end
            end
        end
        n_tests++;
        if (rdy_low != 2) begin n_fail++; $display("FAIL single_ready_low got %0d cycles, want 2", rdy_low); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] sa [8], sb [8], eu [8], ed [8], em [8];
        sa = '{1, 2, 3, 4, 21, 22, 23, 24};   sb = '{11, 12, 13, 14, 31, 32, 33, 34};
        eu = '{1, 2, 11, 12, 21, 22, 31, 32}; ed = '{3, 4, 13, 14, 23, 24, 33, 34};
        em = '{193, 193, 193, 193, 57, 57, 57, 57};
        ncap = 0;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) tick(1'b1, 1'(i == 7), sa[i], sb[i], (i < 4) ? W'(193) : W'(57));
            else       tick(1'b0, 1'b0, '0, '0, '0);
            n_tests++;
            if (out_valid !== exp_vld || in_ready !== exp_ready || busy !== exp_busy || err !== exp_err ||
                out_last !== exp_last || (exp_vld && (out_up !== exp_up || out_down !== exp_down || modulus_out !== exp_mod))) begin
                n_fail++;
                $display("FAIL b2b cyc=%0d got v%b r%b b%b e%b l%b %0d/%0d m%0d, want v%b r%b b%b e%b l%b %0d/%0d m%0d",
                         cyc, out_valid, in_ready, busy, err, out_last, out_up, out_down, modulus_out,
                         exp_vld, exp_ready, exp_busy, exp_err, exp_last, exp_up, exp_down, exp_mod);
            end
            if (out_valid && ncap < 32) begin
                cap_up[ncap] = out_up; cap_dn[ncap] = out_down; cap_md[ncap] = modulus_out;
                cap_last[ncap] = out_last; cap_cyc[ncap] = cyc; ncap++;
            end
        end
        n_tests++;
        if (ncap != 8) begin n_fail++; $display("FAIL b2b_count got %0d pairs, want 8", ncap); end
        for (int i = 0; i < 8 && i < ncap; i++) begin
            n_tests++;
            if (cap_up[i] !== eu[i] || cap_dn[i] !== ed[i] || cap_md[i] !== em[i] || cap_last[i] !== (i == 7) ||
                (i > 0 && cap_cyc[i] != cap_cyc[i-1] + 1)) begin
                n_fail++;
                $display("FAIL b2b_pair%0d got (%0d,%0d) m%0d l%b cyc%0d, want (%0d,%0d) m%0d l%b with no gap",
                         i, cap_up[i], cap_dn[i], cap_md[i], cap_last[i], cap_cyc[i], eu[i], ed[i], em[i], (i == 7));
            end
        end
    endtask

    task automatic test_stalls();
        logic [W-1:0] eu [4], ed [4];
        eu = '{1, 2, 11, 12}; ed = '{3, 4, 13, 14};
        ncap = 0;
        for (int i = 0; i < 14; i++) begin
            if (i < 8 && (i % 2) == 1) tick(1'b1, 1'(i == 7), W'(i/2+1), W'(i/2+11), W'(193));
            else                       tick(1'b0, 1'b0, W'($urandom()), W'($urandom()), W'(193));
            n_tests++;
            if (out_valid !== exp_vld || in_ready !== exp_ready || busy !== exp_busy || err !== exp_err ||
                out_last !== exp_last || (exp_vld && (out_up !== exp_up || out_down !== exp_down || modulus_out !== exp_mod))) begin
                n_fail++;
                $display("FAIL stall cyc=%0d got v%b r%b b%b e%b l%b %0d/%0d m%0d, want v%b r%b b%b e%b l%b %0d/%0d m%0d",
                         cyc, out_valid, in_ready, busy, err, out_last, out_up, out_down, modulus_out,
                         exp_vld, exp_ready, exp_busy, exp_err, exp_last, exp_up, exp_down, exp_mod);
            end
            if (out_valid && ncap < 32) begin
                cap_up[ncap] = out_up; cap_dn[ncap] = out_down; cap_last[ncap] = out_last; ncap++;
            end
        end
        n_tests++;
        if (ncap != 4) begin n_fail++; $display("FAIL stall_count got %0d pairs, want 4", ncap); end
        for (int i = 0; i < 4 && i < ncap; i++) begin
            n_tests++;
            if (cap_up[i] !== eu[i] || cap_dn[i] !== ed[i] || cap_last[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL stall_pair%0d got (%0d,%0d) l%b, want (%0d,%0d) l%b",
                         i, cap_up[i], cap_dn[i], cap_last[i], eu[i], ed[i], (i == 3));
            end
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, W'(90+i), W'(95+i), W'(77));
            n_tests++;
            if (out_valid !== exp_vld || in_ready !== exp_ready || busy !== exp_busy || err !== exp_err) begin
                n_fail++;
                $display("FAIL pre_rst cyc=%0d got v%b r%b b%b e%b, want v%b r%b b%b e%b",
                         cyc, out_valid, in_ready, busy, err, exp_vld, exp_ready, exp_busy, exp_err);
            end
        end
        test_reset();
        test_single_block();
    endtask

    task automatic test_misaligned_last();
        logic [W-1:0] eu [4], ed [4];
        int want_err;
        eu = '{1, 2, 11, 12}; ed = '{3, 4, 13, 14};
        ncap = 0; n_err = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 4)      tick(1'b1, 1'(i == 1 || i == 3), W'(i+1), W'(i+11), W'(193));
            else if (i < 6) tick(1'b1, 1'b0, W'(99), W'(99), W'(193));
            else            tick(1'b0, 1'b0, '0, '0, '0);
            n_tests++;
            if (out_valid !== exp_vld || in_ready !== exp_ready || busy !== exp_busy || err !== exp_err ||
                out_last !== exp_last || (exp_vld && (out_up !== exp_up || out_down !== exp_down || modulus_out !== exp_mod))) begin
                n_fail++;
                $display("FAIL misalign cyc=%0d got v%b r%b b%b e%b l%b %0d/%0d m%0d, want v%b r%b b%b e%b l%b %0d/%0d m%0d",
                         cyc, out_valid, in_ready, busy, err, out_last, out_up, out_down, modulus_out,
                         exp_vld, exp_ready, exp_busy, exp_err, exp_last, exp_up, exp_down, exp_mod);
            end
            if (out_valid && ncap < 32) begin
                cap_up[ncap] = out_up; cap_dn[ncap] = out_down; cap_last[ncap] = out_last; ncap++;
            end
            if (err === 1'b1) n_err++;
        end
`ifdef MDC_ERR_CHECK_EN
        want_err = 3;
`else
        want_err = 0;
`endif
        n_tests++;
        if (n_err != want_err) begin n_fail++; $display("FAIL misalign_err_pulses got %0d, want %0d", n_err, want_err); end
        n_tests++;
        if (ncap != 4) begin n_fail++; $display("FAIL misalign_count got %0d pairs, want 4", ncap); end
        for (int i = 0; i < 4 && i < ncap; i++) begin
            n_tests++;
            if (cap_up[i] !== eu[i] || cap_dn[i] !== ed[i] || cap_last[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL misalign_pair%0d got (%0d,%0d) l%b, want (%0d,%0d) l%b",
                         i, cap_up[i], cap_dn[i], cap_last[i], eu[i], ed[i], (i == 3));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                 W'($urandom()), W'($urandom()), W'($urandom()));
            n_tests++;
            if (out_valid !== exp_vld || in_ready !== exp_ready || busy !== exp_busy || err !== exp_err ||
                out_last !== exp_last || (exp_vld && (out_up !== exp_up || out_down !== exp_down || modulus_out !== exp_mod))) begin
                n_fail++;
                $display("FAIL random cyc=%0d got v%b r%b b%b e%b l%b %0d/%0d m%0d, want v%b r%b b%b e%b l%b %0d/%0d m%0d",
                         cyc, out_valid, in_ready, busy, err, out_last, out_up, out_down, modulus_out,
                         exp_vld, exp_ready, exp_busy, exp_err, exp_last, exp_up, exp_down, exp_mod);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_stalls();
        test_reset_midstream();
        test_misaligned_last();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
